// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - stall, flush and forwarding controller for the 5-stage LEGv8 pipeline
//
// Keeps a shadow copy of in-flight instruction metadata (E, M, W) fed from
// decode. All control outputs are combinational from the shadow slots and the
// current inputs.
//
// Optional feature macro: HAZARD_FORWARD_EN
//   defined   : execute-stage forwarding from M/W, stalls only on load-use
//   undefined : no forwarding, decode stalls on any in-flight RAW producer
//
// Ports:
//   clk, reset                 clock (rising edge), async active-high reset
//   rn_D, rm_D, usesRn_D/Rm_D  decode source registers and their read enables
//   rd_D, regWrite_D           decode destination and its write enable
//   memRead_D, valid_D         decode is a load / decode slot holds a real instruction
//   brTaken_M                  branch resolved taken in memory stage
//   stall_F, stall_D           hold PC / hold IF/ID
//   flush_D, flush_E, flush_M  clear IF/ID, ID/EX, EX/MEM
//   forwardA_E, forwardB_E     operand selects: 00 regfile, 01 WB, 10 MEM
//   stallCnt, flushCnt         stall-cycle and taken-branch flush counters
module hazard_ctrl #(
    parameter int REG_W    = 5,
    parameter int CNT_W    = 32,
    parameter int ZERO_REG = 31
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] rn_D,
    input  logic [REG_W-1:0] rm_D,
    input  logic             usesRn_D,
    input  logic             usesRm_D,
    input  logic [REG_W-1:0] rd_D,
    input  logic             regWrite_D,
    input  logic             memRead_D,
    input  logic             valid_D,
    input  logic             brTaken_M,
    output logic             stall_F,
    output logic             stall_D,
    output logic             flush_D,
    output logic             flush_E,
    output logic             flush_M,
    output logic [1:0]       forwardA_E,
    output logic [1:0]       forwardB_E,
    output logic [CNT_W-1:0] stallCnt,
    output logic [CNT_W-1:0] flushCnt
);

    localparam logic [REG_W-1:0] ZR = REG_W'(ZERO_REG);

    typedef struct packed {
        logic             v;
        logic [REG_W-1:0] rd;
        logic             rw;
        logic             mr;
    } slot_t;

    typedef struct packed {
        slot_t            s;
        logic [REG_W-1:0] rn;
        logic [REG_W-1:0] rm;
        logic             use_rn;
        logic             use_rm;
    } eslot_t;

    eslot_t           e_q, e_d;
    slot_t            m_q, m_d;
    slot_t            w_q, w_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             hz;

    // XZR is never a producer, whatever the slot says.
    function automatic logic match(input logic [REG_W-1:0] r, input slot_t s);
        return s.v & s.rw & (s.rd == r) & (r != ZR);
    endfunction

    // M is one instruction newer than W, so it wins when both match.
    function automatic logic [1:0] fwd_sel(input logic rd_en, input logic [REG_W-1:0] r,
                                           input slot_t ms, input slot_t ws);
        if (rd_en & match(r, ms)) return 2'b10;
        if (rd_en & match(r, ws)) return 2'b01;
        return 2'b00;
    endfunction

    always_comb begin
        stall_F    = 1'b0;
        stall_D    = 1'b0;
        flush_D    = 1'b0;
        flush_E    = 1'b0;
        flush_M    = 1'b0;
        forwardA_E = 2'b00;
        forwardB_E = 2'b00;
`ifdef HAZARD_FORWARD_EN
        // Only a load in E cannot be forwarded in time.
        hz = valid_D & e_q.s.mr &
             ((usesRn_D & match(rn_D, e_q.s)) | (usesRm_D & match(rm_D, e_q.s)));
`else
        hz = valid_D &
             ((usesRn_D & (match(rn_D, e_q.s) | match(rn_D, m_q) | match(rn_D, w_q))) |
              (usesRm_D & (match(rm_D, e_q.s) | match(rm_D, m_q) | match(rm_D, w_q))));
`endif
        if (!reset) begin
            if (brTaken_M) begin
                flush_D = 1'b1;
                flush_E = 1'b1;
                flush_M = 1'b1;
            end else if (hz) begin
                stall_F = 1'b1;
                stall_D = 1'b1;
                flush_E = 1'b1;
            end
`ifdef HAZARD_FORWARD_EN
            forwardA_E = fwd_sel(e_q.use_rn, e_q.rn, m_q, w_q);
            forwardB_E = fwd_sel(e_q.use_rm, e_q.rm, m_q, w_q);
`endif
        end
    end

    always_comb begin
        w_d         = m_q;
        m_d         = flush_M ? '0 : e_q.s;
        e_d         = '0;
        if (!flush_E) begin
            e_d.s.v    = valid_D;
            e_d.s.rd   = rd_D;
            e_d.s.rw   = regWrite_D;
            e_d.s.mr   = memRead_D;
            e_d.rn     = rn_D;
            e_d.rm     = rm_D;
            e_d.use_rn = usesRn_D;
            e_d.use_rm = usesRm_D;
        end
        stall_cnt_d = stall_cnt_q + CNT_W'(stall_D);
        flush_cnt_d = flush_cnt_q + CNT_W'(brTaken_M);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            e_q         <= '0;
            m_q         <= '0;
            w_q         <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            e_q         <= e_d;
            m_q         <= m_d;
            w_q         <= w_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stallCnt = stall_cnt_q;
    assign flushCnt = flush_cnt_q;

    // Metadata carried down the shadow pipe that a given build does not consume.
    logic unused_meta;
    assign unused_meta = ^{m_q.mr, w_q.mr, e_q.s.mr, e_q.rn, e_q.rm, e_q.use_rn, e_q.use_rm};

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - scoreboard bench for hazard_ctrl against an in-flight-list reference model
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [4:0]  rn_D = '0, rm_D = '0, rd_D = '0;
    logic        usesRn_D = 1'b0, usesRm_D = 1'b0, regWrite_D = 1'b0;
    logic        memRead_D = 1'b0, valid_D = 1'b0, brTaken_M = 1'b0;
    logic        stall_F, stall_D, flush_D, flush_E, flush_M;
    logic [1:0]  forwardA_E, forwardB_E;
    logic [31:0] stallCnt, flushCnt;

    hazard_ctrl dut (
        .clk(clk), .reset(reset),
        .rn_D(rn_D), .rm_D(rm_D), .usesRn_D(usesRn_D), .usesRm_D(usesRm_D),
        .rd_D(rd_D), .regWrite_D(regWrite_D), .memRead_D(memRead_D),
        .valid_D(valid_D), .brTaken_M(brTaken_M),
        .stall_F(stall_F), .stall_D(stall_D), .flush_D(flush_D),
        .flush_E(flush_E), .flush_M(flush_M),
        .forwardA_E(forwardA_E), .forwardB_E(forwardB_E),
        .stallCnt(stallCnt), .flushCnt(flushCnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       v;
        logic [4:0] rd;
        logic       rw;
        logic       mr;
        logic [4:0] rn;
        logic [4:0] rm;
        logic       urn;
        logic       urm;
    } ins_t;

    typedef struct packed {
        logic        sF, sD, fD, fE, fM;
        logic [1:0]  fa, fb;
        logic [31:0] sc, fc;
    } exp_t;

    exp_t        exp_q[$];
    ins_t        pipe[$];      // in-flight instructions, index = age (0 = E, 1 = M, 2 = W)
    int unsigned m_stall, m_flush;
    int          checks = 0;
    int          failures = 0;

    function automatic ins_t alu(input int rd, input int rn, input int rm);
        ins_t d = '0;
        d.v = 1; d.rw = 1; d.rd = 5'(rd); d.rn = 5'(rn); d.rm = 5'(rm); d.urn = 1; d.urm = 1;
        return d;
    endfunction

    function automatic ins_t ldur(input int rd, input int rn);
        ins_t d = '0;
        d.v = 1; d.rw = 1; d.mr = 1; d.rd = 5'(rd); d.rn = 5'(rn); d.urn = 1;
        return d;
    endfunction

    function automatic logic [4:0] pick_reg();
        int k = $urandom_range(0, 4);
        return (k == 4) ? 5'd31 : 5'(k + 1);
    endfunction

    function automatic ins_t rnd_ins();
        ins_t d;
        d.v   = ($urandom_range(0, 7) != 0);
        d.rw  = ($urandom_range(0, 3) != 0);
        d.mr  = d.rw && ($urandom_range(0, 2) == 0);
        d.rd  = pick_reg();
        d.rn  = pick_reg();
        d.rm  = pick_reg();
        d.urn = ($urandom_range(0, 3) != 0);
        d.urm = ($urandom_range(0, 1) != 0);
        return d;
    endfunction

    // True when an in-flight instruction will produce architectural register r.
    function automatic bit produces(input ins_t p, input logic [4:0] r);
        return p.v && p.rw && (p.rd == r) && (r != 5'd31);
    endfunction

    function automatic bit needs(input ins_t d, input ins_t p);
        return (d.urn && produces(p, d.rn)) || (d.urm && produces(p, d.rm));
    endfunction

    // Nearest older producer: one stage ahead means MEM, two means WB.
    function automatic logic [1:0] fwd_code(input bit rd_en, input logic [4:0] r);
        for (int age = 1; age <= 2; age++)
            if (rd_en && produces(pipe[age], r)) return (age == 1) ? 2'b10 : 2'b01;
        return 2'b00;
    endfunction

    function automatic void model_clear();
        pipe.delete();
        repeat (3) pipe.push_back('0);
        m_stall = 0;
        m_flush = 0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic apply(input ins_t d, input logic br);
        valid_D = d.v; rd_D = d.rd; regWrite_D = d.rw; memRead_D = d.mr;
        rn_D = d.rn; rm_D = d.rm; usesRn_D = d.urn; usesRm_D = d.urm; brTaken_M = br;
    endtask

    // Drive one decode cycle, push the model's expectation, advance the model.
    task automatic drive(input ins_t d, input logic br, output bit stalled);
        exp_t e = '0;
        bit   hz = 0;
        ins_t new_e, old_e;
        apply(d, br);
`ifdef HAZARD_FORWARD_EN
        hz = d.v && pipe[0].mr && needs(d, pipe[0]);
        e.fa = pipe[0].urn ? fwd_code(1'b1, pipe[0].rn) : 2'b00;
        e.fb = pipe[0].urm ? fwd_code(1'b1, pipe[0].rm) : 2'b00;
`else
        for (int age = 0; age < 3; age++) if (d.v && needs(d, pipe[age])) hz = 1;
`endif
        if (br) begin
            e.fD = 1; e.fE = 1; e.fM = 1;
        end else if (hz) begin
            e.sF = 1; e.sD = 1; e.fE = 1;
        end
        e.sc = m_stall;
        e.fc = m_flush;
        exp_q.push_back(e);
        stalled = e.sD;
        if (e.sD) m_stall++;
        if (br)   m_flush++;
        new_e = e.fE ? '0 : d;
        old_e = e.fM ? '0 : pipe[0];
        void'(pipe.pop_back());
        pipe[0] = old_e;
        pipe.push_front(new_e);
        @(posedge clk); #1;
    endtask

    // Issue as a real pipeline would: re-present the decode while it is stalled.
    task automatic issue(input ins_t d);
        bit st = 1;
        for (int k = 0; k < 6 && st; k++) drive(d, 1'b0, st);
    endtask

    task automatic nops(input int n);
        for (int k = 0; k < n; k++) issue('0);
    endtask

    // Assert reset with hazard-provoking inputs present; every output must read zero.
    task automatic hold_reset(input int n);
        reset = 1'b1;
        for (int k = 0; k < n; k++) begin
            apply(alu(5, 5, 5), 1'b1);
            exp_q.push_back('0);
            @(posedge clk); #1;
        end
        reset = 1'b0;
        model_clear();
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("stall_F",    32'(stall_F),    32'(e.sF));
                chk("stall_D",    32'(stall_D),    32'(e.sD));
                chk("flush_D",    32'(flush_D),    32'(e.fD));
                chk("flush_E",    32'(flush_E),    32'(e.fE));
                chk("flush_M",    32'(flush_M),    32'(e.fM));
                chk("forwardA_E", 32'(forwardA_E), 32'(e.fa));
                chk("forwardB_E", 32'(forwardB_E), 32'(e.fb));
                chk("stallCnt",   stallCnt,        e.sc);
                chk("flushCnt",   flushCnt,        e.fc);
            end
        end
    end

    initial begin : stimulus
        bit   st;
        ins_t d;
        model_clear();
        @(posedge clk); #1;
        hold_reset(2);

        // ALU result forwarded from MEM, then from WB with a NOP between.
        issue(alu(1, 2, 3)); issue(alu(2, 1, 3)); nops(3);
        issue(alu(1, 2, 3)); issue('0); issue(alu(2, 1, 3)); nops(3);
        // Two back-to-back writers of X4: the newest one must be selected.
        issue(alu(4, 1, 2)); issue(alu(4, 2, 3)); issue(alu(7, 4, 1)); nops(3);
        // Load-use: one bubble, then both operands from WB.
        issue(ldur(5, 1)); issue(alu(6, 5, 5)); nops(3);
        // XZR is never a hazard source.
        issue(ldur(31, 1)); issue(alu(6, 31, 31)); nops(3);
        // Taken branch coincident with a load-use pair.
        issue(ldur(5, 1)); drive(alu(6, 5, 5), 1'b1, st); nops(3);
        // Reset mid-stream with a load in E, then a reader of the same register.
        issue(ldur(5, 1)); hold_reset(1); issue(alu(6, 5, 5)); nops(3);

        // Randomized traffic; a stalled decode is re-presented unless a branch flushes it.
        st = 0;
        d  = rnd_ins();
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                hold_reset(1);
                st = 0;
            end
            if (!st) d = rnd_ins();
            drive(d, ($urandom_range(0, 7) == 0), st);
        end
        apply('0, 1'b0);

        @(negedge clk); #1;
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain actual=%0d required=0 pending expectations", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage LEGv8 core: sequences F/D/E/M/W via stall, flush and forwarding controls.
- Keeps its own shadow pipeline of in-flight instruction metadata (E, M, W slots) fed from decode. It does not snoop the pipeline registers.
- Drives execute-stage operand forwarding selects, load-use stalls and taken-branch flushes.
- Maintains stall/flush performance counters.

Parameters:
- REG_W, 5, register specifier width.
- CNT_W, 32, performance counter width.
- ZERO_REG, 31, hardwired-zero register index (XZR). Never a hazard source.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- rn_D  in  REG_W  decode source register 1.
- rm_D  in  REG_W  decode source register 2.
- usesRn_D  in  1  decode instruction reads rn_D.
- usesRm_D  in  1  decode instruction reads rm_D.
- rd_D  in  REG_W  decode destination register.
- regWrite_D  in  1  decode instruction writes rd_D.
- memRead_D  in  1  decode instruction is a load.
- valid_D  in  1  decode slot holds a real instruction.
- brTaken_M  in  1  branch resolved taken in memory stage (PCSrc).
- stall_F  out  1  hold PC.
- stall_D  out  1  hold IF/ID.
- flush_D  out  1  clear IF/ID.
- flush_E  out  1  clear ID/EX (insert bubble).
- flush_M  out  1  clear EX/MEM.
- forwardA_E  out  2  execute operand A select: 00 regfile, 01 WB result, 10 MEM aluResult.
- forwardB_E  out  2  same encoding for operand B (pre-AluSrc mux).
- stallCnt  out  CNT_W  cycles with stall_D high.
- flushCnt  out  CNT_W  taken-branch flush events.

Behaviour:
- Shadow slots:
  - E holds {v, rd, rw, mr, rn, rm, usesRn, usesRm}.
  - M and W hold {v, rd, rw, mr}.
- Reset: all slot v=0, counters 0. All control outputs are combinational from slots and inputs, so they read 0 while reset is asserted and immediately after it.
- Match(r, slot) = slot.v & slot.rw & (slot.rd == r) & (r != ZERO_REG).
- Load-use hazard (LU) = valid_D & E.mr & ((usesRn_D & Match(rn_D, E)) | (usesRm_D & Match(rm_D, E))).
- Priority, highest first:
  - brTaken_M: flush_D=flush_E=flush_M=1, stall_F=stall_D=0. LU is ignored.
  - LU: stall_F=stall_D=1, flush_E=1. Exactly one bubble per load-use pair.
  - Otherwise: all stall/flush outputs 0.
- Forwarding (with FORWARD_EN):
  - forwardA_E=10 if E.usesRn & Match(E.rn, M).
  - Else forwardA_E=01 if E.usesRn & Match(E.rn, W).
  - Else forwardA_E=00.
  - forwardB_E follows the same rule using E.rm / E.usesRm.
  - The M slot wins over W when both match.
  - Independent of brTaken_M.
- Slot update on each rising clk:
  - W <= M.
  - M <= E, or a bubble (v=0) if flush_M.
  - E <= decode fields with v=valid_D, or a bubble if flush_E.
- Counters:
  - stallCnt += 1 when stall_D. flushCnt += 1 when brTaken_M.
  - Both wrap modulo 2^CNT_W.
- Async reset mid-operation: all slots invalidated immediately; any pending stall is released.
- Latency: zero-cycle combinational outputs. Slot state lags the pipeline by 0 stages, since it is updated on the same edge as the pipeline registers.

Optional Feature:
- Macro: HAZARD_FORWARD_EN.
- Defined: forwarding as above; stalls only for load-use.
- Undefined:
  - forwardA_E=forwardB_E=00 constantly.
  - RAW stall condition = valid_D & ((usesRn_D & (Match(rn_D,E)|Match(rn_D,M)|Match(rn_D,W))) | (usesRm_D & same for rm_D)).
  - Asserts stall_F=stall_D=flush_E, repeated each cycle until the producer leaves W.
  - Branch flush priority is unchanged.

Test Plan:
- Reset:
  - Assert reset mid-stream with a load in E → all outputs 0 during reset.
  - Counters 0.
  - No stall on the first post-reset decode that reads the same register.
- ALU forward:
  - ADD X1 then SUB X2,X1,X3 back-to-back → SUB in E sees forwardA_E=10.
  - With one NOP between them → forwardA_E=01.
- Double match:
  - Back-to-back writes to X4, then a reader of X4 → forwardA_E=10 (newest wins).
- Load-use:
  - LDUR X5 then ADD X6,X5,X5 → exactly one cycle of stall_F=stall_D=flush_E=1, stallCnt=1.
  - Then forwardA_E=forwardB_E=01.
- XZR:
  - LDUR X31 followed by a reader of X31 → no stall, forward=00.
- Branch:
  - brTaken_M=1 coincident with an LU condition → flush_D/E/M=1, stall=0, flushCnt=1.
  - Next cycle E and M slots are bubbles.
  - Without HAZARD_FORWARD_EN, the ADD X1→SUB X1 pair stalls 3 cycles.
